// File: rtl/pipelined_subtractor.sv
// Pipelined WIDTH-bit subtractor D = A - B - BI, one SW-bit ripple-borrow slice per stage.
// The whole pipeline advances or stalls together under a valid/ready handshake.
module pipelined_subtractor #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             V,
  output logic             OutValid,
  input  logic             OutReady
);

  // WIDTH must divide evenly into STAGES slices; STAGES >= 2 and SW >= 2 are assumed.
  localparam int SW = WIDTH / STAGES;

  // Handshake: a transfer happens on a Clock edge where valid && ready. InReady is
  // derived only from output-side state, never from InValid.
  logic [WIDTH-1:0] r_a   [STAGES-1];
  logic [WIDTH-1:0] r_b   [STAGES-1];
  logic [WIDTH-1:0] r_d   [STAGES];
  logic             r_bo  [STAGES];
  logic             r_vld [STAGES];
  logic             r_v;
  logic             w_adv;

  assign w_adv    = !r_vld[STAGES-1] || OutReady;
  assign InReady  = w_adv;
  assign D        = r_d[STAGES-1];
  assign BO       = r_bo[STAGES-1];
  assign V        = r_v;
  assign OutValid = r_vld[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    w_as;
    logic [SW-1:0]    w_bs;
    logic [WIDTH-1:0] w_din;
    logic             w_bin;
    logic             w_vin;
    logic [SW:0]      w_slice;
    logic [WIDTH-1:0] w_dnext;

    if (k == 0) begin : g_first
      assign w_as  = A[0 +: SW];
      assign w_bs  = B[0 +: SW];
      assign w_din = '0;
      assign w_bin = BI;
      assign w_vin = InValid;
    end else begin : g_next
      assign w_as  = r_a[k-1][k*SW +: SW];
      assign w_bs  = r_b[k-1][k*SW +: SW];
      assign w_din = r_d[k-1];
      assign w_bin = r_bo[k-1];
      assign w_vin = r_vld[k-1];
    end

    // Top bit of the widened difference is the slice borrow-out.
    assign w_slice = {1'b0, w_as} - {1'b0, w_bs} - {{SW{1'b0}}, w_bin};

    always_comb begin
      w_dnext = w_din;
      w_dnext[k*SW +: SW] = w_slice[SW-1:0];
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        r_d[k]   <= '0;
        r_bo[k]  <= 1'b0;
        r_vld[k] <= 1'b0;
      end else if (w_adv) begin
        r_d[k]   <= w_dnext;
        r_bo[k]  <= w_slice[SW];
        r_vld[k] <= w_vin;
      end
    end

    if (k < STAGES - 1) begin : g_pass
      logic [WIDTH-1:0] w_a_src;
      logic [WIDTH-1:0] w_b_src;
      if (k == 0) begin : g_src_in
        assign w_a_src = A;
        assign w_b_src = B;
      end else begin : g_src_reg
        assign w_a_src = r_a[k-1];
        assign w_b_src = r_b[k-1];
      end

      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_a[k] <= '0;
          r_b[k] <= '0;
        end else if (w_adv) begin
          r_a[k] <= w_a_src;
          r_b[k] <= w_b_src;
        end
      end
    end else begin : g_top
      // Borrow into the MSB comes from the low SW-1 bits of the top slice.
      logic [SW-1:0] w_low;
      assign w_low = {1'b0, w_as[SW-2:0]} - {1'b0, w_bs[SW-2:0]}
                   - {{(SW-1){1'b0}}, w_bin};

      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_v <= w_low[SW-1] ^ w_slice[SW];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed and random checks of pipelined_subtractor: latency, borrow/overflow flags,
// stall stability, reset flush and in-order delivery against a reference model.
module tb_pipelined_subtractor;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic        bi;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] d;
  logic        bo, v;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] exp_q[$];
  logic        hold;
  logic [34:0] held;

  pipelined_subtractor dut (
    .Clock   (clk),
    .Reset   (rst),
    .A       (a),
    .B       (b),
    .BI      (bi),
    .InValid (in_valid),
    .InReady (in_ready),
    .D       (d),
    .BO      (bo),
    .V       (v),
    .OutValid(out_valid),
    .OutReady(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mbi);
    logic [32:0] u;
    logic [33:0] s;
    u = {1'b0, ma} - {1'b0, mb} - {32'd0, mbi};
    s = {{2{ma[31]}}, ma} - {{2{mb[31]}}, mb} - {33'd0, mbi};
    return {u[32], s[32] ^ s[31], u[31:0]};
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic dbi,
                       input logic dv);
    a = da; b = db; bi = dbi; in_valid = dv;
  endtask

  task automatic send(input logic [31:0] da, input logic [31:0] db, input logic dbi);
    drive(da, db, dbi, 1'b1);
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] ed, input logic ebo,
                          input logic ev);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      found = out_valid;
    end
    check({tag, "_seen"}, found, 1'b1);
    if (found) begin
      check({tag, "_d"}, d, ed);
      check({tag, "_bo"}, bo, ebo);
      check({tag, "_v"}, v, ev);
    end
  endtask

  // scoreboard: handshake rules, stall stability, in-order results
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (hold) check("stall_stable", {out_valid, bo, v, d}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
        else check("result", {bo, v, d}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bi));
      hold = out_valid && !out_ready;
      held = {out_valid, bo, v, d};
    end
  end

  initial begin
    int idx;
    int budget;
    hold = 1'b0;
    held = '0;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_d", d, 32'h0);
    check("rst_bo", bo, 1'b0);
    check("rst_v", v, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    #1;
    rst = 1'b0;
    next_cycle();

    // single op with exact latency
    send(32'h5, 32'h3, 1'b0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check($sformatf("lat_valid_%0d", j), out_valid, j == 4);
      if (j == 4) begin
        check("single_d", d, 32'h2);
        check("single_bo", bo, 1'b0);
        check("single_v", v, 1'b0);
      end
    end
    next_cycle();

    // cross-slice borrow and wrap-around
    send(32'h0001_0000, 32'h0000_0001, 1'b0);
    wait_out("xslice", 32'h0000_FFFF, 1'b0, 1'b0);
    next_cycle();
    send(32'h0, 32'h0, 1'b1);
    wait_out("wrap", 32'hFFFF_FFFF, 1'b1, 1'b0);
    next_cycle();

    // signed overflow
    send(32'h8000_0000, 32'h0000_0001, 1'b0);
    wait_out("ovf_neg", 32'h7FFF_FFFF, 1'b0, 1'b1);
    next_cycle();
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_out("ovf_pos", 32'h8000_0000, 1'b1, 1'b1);
    next_cycle();

    // back-to-back with a stall window
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 6 && c <= 9);
      if (idx < 8) drive(idx * 32'h0101_0101, idx, 1'b0, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (idx < 8 && in_ready) idx++;
      next_cycle();
    end
    check("burst_accepted", idx, 8);
    check("burst_drained", exp_q.size(), 0);

    // reset mid-flight
    out_ready = 1'b1;
    send(32'h1111_1111, 32'h0000_0001, 1'b0);
    send(32'h2222_2222, 32'h0000_0002, 1'b0);
    drive(32'h3333_3333, 32'h0000_0003, 1'b0, 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_d", d, 32'h0);
    check("midrst_bo", bo, 1'b0);
    check("midrst_v", v, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("midrst_quiet", out_valid, 1'b0);
    end
    next_cycle();
    send(32'h1234_5678, 32'h0234_5678, 1'b0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check($sformatf("postrst_valid_%0d", j), out_valid, j == 4);
      if (j == 4) check("postrst_d", d, 32'h1000_0000);
    end
    next_cycle();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 9) < 7;
      next_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      next_cycle();
      budget++;
    end
    check("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Pipelined 32-bit subtractor computing D = A - B - BI, where BI is the borrow-in.
- It is the inverse-operation counterpart of the team's 4-stage pipelined adder and uses the same slice-per-stage structure: 8 bits per stage, with the borrow registered between stages.
- Adds a valid/ready handshake with whole-pipeline stall, so it can sit in the datapath ahead of a downstream consumer that applies back-pressure.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; slice width SW = WIDTH/STAGES (8 by default).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  minuend, unsigned or two's complement.
- B  input  WIDTH  subtrahend.
- BI  input  1  borrow-in.
- InValid  input  1  A/B/BI valid this cycle.
- InReady  output  1  pipeline accepts input this cycle.
- D  output  WIDTH  difference.
- BO  output  1  borrow-out; 1 iff A < B + BI, unsigned.
- V  output  1  signed overflow of A - B - BI.
- OutValid  output  1  D/BO/V hold a valid result.
- OutReady  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset is synchronous, active-high; when sampled high at a Clock edge:
  - all stage valid bits, OutValid, D, BO and V are cleared to 0;
  - all operand/partial-result registers are cleared to 0;
  - in-flight data is discarded; no result from before reset ever appears afterwards.
- Advance condition: adv = !OutValid || OutReady (combinational). InReady = adv; it must not depend combinationally on InValid.
- Transfer rules:
  - input transfer occurs when InValid && InReady;
  - output transfer occurs when OutValid && OutReady.
- When adv = 1, every stage register loads from its predecessor. Stage 0 loads {A, B, BI, InValid}.
- When adv = 0, every stage register (data, borrow and valid bit) holds its value. D/BO/V stay stable while OutValid = 1 and OutReady = 0.
- Bubbles: invalid slots advance like valid ones, carrying valid bit 0. The pipeline does not compact bubbles.
- Stage k (k = 0..STAGES-1):
  - computes slice k: {b_out, d[k*SW +: SW]} = A_k[slice] - B_k[slice] - b_in, using an SW-bit ripple-borrow subtract;
  - b_in for stage 0 is BI; for stage k > 0 it is the registered borrow from stage k-1;
  - stage k passes A/B unchanged and passes the lower difference slices already computed;
  - stage k registers b_out.
- Final stage registers the full D, BO = b_out of the top slice, and V.
- V = borrow into bit WIDTH-1 XOR borrow out of bit WIDTH-1, computed inside the top slice.
- Latency: a result appears on D/OutValid exactly STAGES advancing cycles after input acceptance (4 cycles with no stall). Throughput is 1 result per cycle while OutReady = 1.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Simultaneous events:
  - input accept and output drain in the same cycle are both legal and occur at full rate;
  - Reset has priority over every handshake.
- Wrap-around: results are modulo 2^WIDTH; BO flags wrap, e.g. 0 - 1 = 0xFFFFFFFF with BO = 1.
- No state machine beyond the STAGES valid-bit shift chain.

Test Plan:
- Single op: A = 0x0000_0005, B = 0x0000_0003, BI = 0, InValid for 1 cycle, OutReady = 1 → OutValid high exactly 4 cycles later for 1 cycle; D = 0x0000_0002, BO = 0, V = 0.
- Cross-slice borrow: A = 0x0001_0000, B = 0x0000_0001, BI = 0 → D = 0x0000_FFFF, BO = 0. Then A = 0, B = 0, BI = 1 → D = 0xFFFF_FFFF, BO = 1, V = 0.
- Signed overflow: A = 0x8000_0000, B = 0x0000_0001 → D = 0x7FFF_FFFF, V = 1, BO = 0. Then A = 0x7FFF_FFFF, B = 0xFFFF_FFFF → D = 0x8000_0000, V = 1, BO = 1.
- Back-to-back plus stall:
  - stimulus: 8 consecutive ops A = i*0x0101_0101, B = i, with OutReady low for cycles 6–9;
  - required: InReady is low exactly while OutValid && !OutReady; D is held stable; all 8 results emerge in order with no loss or duplication; results are checked against a software reference model.
- Reset mid-flight: accept 3 ops, assert Reset for 1 cycle at cycle 2 → OutValid = 0, D = 0, BO = 0, V = 0 the cycle after; none of the 3 results ever appears; a new op accepted afterwards returns after 4 cycles.
- Random: 10k random A/B/BI with random InValid/OutReady → every result matches A - B - BI modulo 2^32, with BO and V matching the reference, in order.
